// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact fill level, programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses and an optional first-word-fall-through read port.

module sync_fifo_param_chk #(
    parameter int DEPTH           = 16,
    parameter int ALMOST_FULL_TH  = 14,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter int FWFT            = 0
) ();

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_bad
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    if ((ALMOST_FULL_TH < 1) || (ALMOST_FULL_TH > DEPTH)) begin : g_af_bad
        $error("sync_fifo: ALMOST_FULL_TH must lie in 1..DEPTH");
    end

    if ((ALMOST_EMPTY_TH < 0) || (ALMOST_EMPTY_TH > DEPTH - 1)) begin : g_ae_bad
        $error("sync_fifo: ALMOST_EMPTY_TH must lie in 0..DEPTH-1");
    end

    if ((FWFT != 0) && (FWFT != 1)) begin : g_fwft_bad
        $error("sync_fifo: FWFT must be 0 or 1");
    end

endmodule

module sync_fifo #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 16,
    parameter int ALMOST_FULL_TH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter int FWFT            = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       wr_full,
    output logic                       wr_almost_full,
    output logic                       wr_overflow,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_empty,
    output logic                       rd_almost_empty,
    output logic                       rd_underflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_TH_C = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_TH_C = CW'(ALMOST_EMPTY_TH);
    localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

    sync_fifo_param_chk #(
        .DEPTH           (DEPTH),
        .ALMOST_FULL_TH  (ALMOST_FULL_TH),
        .ALMOST_EMPTY_TH (ALMOST_EMPTY_TH),
        .FWFT            (FWFT)
    ) u_param_chk ();

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [AW-1:0]         wptr_r;
    logic [AW-1:0]         rptr_r;
    logic [CW-1:0]         count_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  afull_r;
    logic                  aempty_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic [DATA_WIDTH-1:0] rd_data_r;

    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [AW-1:0]         wptr_nxt_s;
    logic [AW-1:0]         rptr_nxt_s;
    logic [CW-1:0]         count_nxt_s;
    logic [DATA_WIDTH-1:0] rd_data_nxt_s;

    // Accept decisions, pointer advance and next fill count from registered state
    always_comb begin
        wr_acc_s    = wr_en && !full_r;
        rd_acc_s    = rd_en && !empty_r;
        wptr_nxt_s  = wptr_r;
        rptr_nxt_s  = rptr_r;
        count_nxt_s = count_r;

        if (wr_acc_s) begin
            wptr_nxt_s = wptr_r + PTR_ONE_C;
        end else begin
            wptr_nxt_s = wptr_r;
        end

        if (rd_acc_s) begin
            rptr_nxt_s = rptr_r + PTR_ONE_C;
        end else begin
            rptr_nxt_s = rptr_r;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Next read-data value: popped word in standard mode, upcoming head in FWFT mode
    always_comb begin
        rd_data_nxt_s = rd_data_r;
        if (FWFT != 0) begin
            // The new head may be the word being written this very cycle
            if (count_nxt_s != {CW{1'b0}}) begin
                if (wr_acc_s && (wptr_r == rptr_nxt_s)) begin
                    rd_data_nxt_s = wr_data;
                end else begin
                    rd_data_nxt_s = mem_r[rptr_nxt_s];
                end
            end else begin
                rd_data_nxt_s = rd_data_r;
            end
        end else begin
            if (rd_acc_s) begin
                rd_data_nxt_s = mem_r[rptr_r];
            end else begin
                rd_data_nxt_s = rd_data_r;
            end
        end
    end

    // Storage array; contents deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wptr_r] <= wr_data;
        end
    end

    // Pointers, count, registered flags, error pulses and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r      <= {AW{1'b0}};
            rptr_r      <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            afull_r     <= 1'b0;
            aempty_r    <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            rd_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            wptr_r      <= wptr_nxt_s;
            rptr_r      <= rptr_nxt_s;
            count_r     <= count_nxt_s;
            full_r      <= (count_nxt_s == DEPTH_C);
            empty_r     <= (count_nxt_s == {CW{1'b0}});
            afull_r     <= (count_nxt_s >= AF_TH_C);
            aempty_r    <= (count_nxt_s <= AE_TH_C);
            overflow_r  <= wr_en && full_r;
            underflow_r <= rd_en && empty_r;
            rd_data_r   <= rd_data_nxt_s;
        end
    end

    assign wr_full         = full_r;
    assign wr_almost_full  = afull_r;
    assign wr_overflow     = overflow_r;
    assign rd_empty        = empty_r;
    assign rd_almost_empty = aempty_r;
    assign rd_underflow    = underflow_r;
    assign rd_data         = rd_data_r;
    assign level           = count_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: drives a standard-read and an FWFT instance with identical stimulus
// and compares both against a queue-based reference model through a read-data scoreboard.

module tb_sync_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AFT   = 14;
    localparam int AET   = 2;
    localparam int LW    = 5;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic [1:0]    full_s;
    logic [1:0]    afull_s;
    logic [1:0]    ovf_s;
    logic [1:0]    empty_s;
    logic [1:0]    aempty_s;
    logic [1:0]    unf_s;
    logic [LW-1:0] level_s [2];
    logic [DW-1:0] rdata_s [2];

    int checks      = 0;
    int failures    = 0;
    int fail_prints = 0;

    // reference model state
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] sb_q [$];
    bit            m_wa;
    bit            m_ra;
    bit            m_ovf;
    bit            m_unf;
    logic [DW-1:0] last0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_TH(AFT),
                .ALMOST_EMPTY_TH(AET), .FWFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(full_s[0]), .wr_almost_full(afull_s[0]), .wr_overflow(ovf_s[0]),
        .rd_en(rd_en), .rd_data(rdata_s[0]), .rd_empty(empty_s[0]),
        .rd_almost_empty(aempty_s[0]), .rd_underflow(unf_s[0]), .level(level_s[0])
    );

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_TH(AFT),
                .ALMOST_EMPTY_TH(AET), .FWFT(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(full_s[1]), .wr_almost_full(afull_s[1]), .wr_overflow(ovf_s[1]),
        .rd_en(rd_en), .rd_data(rdata_s[1]), .rd_empty(empty_s[1]),
        .rd_almost_empty(aempty_s[1]), .rd_underflow(unf_s[1]), .level(level_s[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
            end
        end
    endtask

    // apply one cycle of stimulus; returns just after the edge that consumed it
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
    endtask

    // behavioural model: FIFO as a queue, accept rules on the pre-edge occupancy
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_q.delete();
                sb_q.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                m_wa  = wr_en && (model_q.size() < DEPTH);
                m_ra  = rd_en && (model_q.size() != 0);
                m_ovf = wr_en && !m_wa;
                m_unf = rd_en && !m_ra;
                if (m_ra) sb_q.push_back(model_q.pop_front());
                if (m_wa) model_q.push_back(wr_data);
            end
        end
    end

    // monitor: every falling edge compare both instances with the model
    initial begin
        last0 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last0 = '0;
            end else if (sb_q.size() > 0) begin
                last0 = sb_q.pop_front();
            end
            for (int i = 0; i < 2; i++) begin
                chk("level", 64'(level_s[i]), 64'(model_q.size()));
                chk("rd_empty", 64'(empty_s[i]), 64'(model_q.size() == 0));
                chk("wr_full", 64'(full_s[i]), 64'(model_q.size() == DEPTH));
                chk("wr_almost_full", 64'(afull_s[i]), 64'(model_q.size() >= AFT));
                chk("rd_almost_empty", 64'(aempty_s[i]), 64'(model_q.size() <= AET));
                chk("wr_overflow", 64'(ovf_s[i]), 64'(m_ovf));
                chk("rd_underflow", 64'(unf_s[i]), 64'(m_unf));
            end
            chk("rd_data_std", 64'(rdata_s[0]), 64'(last0));
            if (model_q.size() > 0) begin
                chk("rd_data_fwft_head", 64'(rdata_s[1]), 64'(model_q[0]));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_level", 64'(level_s[0]), 64'd0);
        chk("reset_empty", 64'(empty_s[0]), 64'd1);
        chk("reset_aempty", 64'(aempty_s[0]), 64'd1);
        chk("reset_full", 64'(full_s[0]), 64'd0);
        chk("reset_afull", 64'(afull_s[0]), 64'd0);
        chk("reset_rd_data", 64'(rdata_s[0]), 64'd0);
        rst = 1'b0;

        // asynchronous reset in the middle of a fill
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i), 1'b0);
        chk("midfill_level", 64'(level_s[0]), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_level", 64'(level_s[0]), 64'd0);
        chk("async_rst_empty", 64'(empty_s[0]), 64'd1);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
        step(1'b0, '0, 1'b0);
        chk("post_rst_level", 64'(level_s[0]), 64'd0);

        // fill to full, then one rejected write
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0);
            chk("fill_level", 64'(level_s[0]), 64'(i + 1));
            chk("fill_afull", 64'(afull_s[0]), 64'((i + 1) >= 14));
            chk("fill_full", 64'(full_s[0]), 64'((i + 1) == 16));
        end
        step(1'b1, 32'h0000_00AA, 1'b0);
        chk("ovf_pulse", 64'(ovf_s[0]), 64'd1);
        chk("ovf_level", 64'(level_s[0]), 64'd16);
        step(1'b0, '0, 1'b0);
        chk("ovf_pulse_end", 64'(ovf_s[0]), 64'd0);

        // drain in order, then one rejected read
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            chk("drain_data", 64'(rdata_s[0]), 64'(i));
        end
        step(1'b0, '0, 1'b1);
        chk("unf_pulse", 64'(unf_s[0]), 64'd1);
        chk("unf_hold_data", 64'(rdata_s[0]), 64'h0F);
        step(1'b0, '0, 1'b0);
        chk("unf_pulse_end", 64'(unf_s[0]), 64'd0);

        // steady read+write at level 8 across pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'($urandom), 1'b1);
            chk("rw_level8", 64'(level_s[0]), 64'd8);
        end
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        // read+write when empty: write wins, read rejected
        step(1'b1, 32'h0000_0055, 1'b1);
        chk("rw_empty_unf", 64'(unf_s[0]), 64'd1);
        chk("rw_empty_level", 64'(level_s[0]), 64'd1);

        // read+write when full: read wins, write rejected
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, DW'($urandom), 1'b0);
        step(1'b1, 32'h0000_0066, 1'b1);
        chk("rw_full_ovf", 64'(ovf_s[0]), 64'd1);
        chk("rw_full_level", 64'(level_s[0]), 64'd15);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // first-word-fall-through behaviour
        step(1'b1, 32'h0000_0011, 1'b0);
        chk("fwft_not_empty", 64'(empty_s[1]), 64'd0);
        chk("fwft_head0", 64'(rdata_s[1]), 64'h11);
        step(1'b1, 32'h0000_0022, 1'b0);
        chk("fwft_head_hold", 64'(rdata_s[1]), 64'h11);
        step(1'b0, '0, 1'b1);
        chk("fwft_head1", 64'(rdata_s[1]), 64'h22);
        step(1'b0, '0, 1'b1);
        chk("fwft_empty", 64'(empty_s[1]), 64'd1);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
        end
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parametrised FIFO; the same-clock counterpart of the team's dual-clock FIFO.
- Used wherever producer and consumer share `clk`.
- Adds features the dual-clock FIFO lacks:
  - programmable almost-full and almost-empty thresholds;
  - an exact fill level;
  - overflow and underflow error pulses;
  - a selectable first-word-fall-through (FWFT) read mode.

Parameters:
- DATA_WIDTH, 32, width of each entry.
- DEPTH, 16, number of entries. Must be a power of two, ≥ 2. Elaborate-time assertion otherwise.
- ALMOST_FULL_TH, DEPTH-2, `wr_almost_full` asserts when level ≥ this value. Range 1..DEPTH.
- ALMOST_EMPTY_TH, 2, `rd_almost_empty` asserts when level ≤ this value. Range 0..DEPTH-1.
- FWFT, 0. 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- wr_full  out  1  FIFO holds DEPTH entries.
- wr_almost_full  out  1  level ≥ ALMOST_FULL_TH.
- wr_overflow  out  1  one-cycle pulse: write rejected.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  read data.
- rd_empty  out  1  FIFO holds 0 entries.
- rd_almost_empty  out  1  level ≤ ALMOST_EMPTY_TH.
- rd_underflow  out  1  one-cycle pulse: read rejected.
- level  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH.

Behaviour:
- Interface: one clock (`clk`); reset `rst` is asynchronous and active-high.

- Storage and pointers:
  - Storage is DEPTH x DATA_WIDTH flops; contents are not reset.
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
  - Count register is $clog2(DEPTH)+1 bits.

- Reset (while `rst` = 1, and immediately on assertion):
  - pointers = 0, level = 0, rd_data = 0;
  - rd_empty = 1, rd_almost_empty = 1, wr_full = 0;
  - wr_almost_full = 0 (given ALMOST_FULL_TH ≥ 1);
  - wr_overflow = 0, rd_underflow = 0.
  - Reset mid-operation discards all contents. The first cycle after deassertion behaves as empty.

- Accept rules (evaluated on the registered state at the clock edge):
  - Write accepted iff wr_en && !wr_full. Writes mem[wptr] <= wr_data and increments wptr.
  - Read accepted iff rd_en && !rd_empty. Increments rptr.
  - Write while full is rejected even if a read is accepted in the same cycle. No pass-through when full.
  - Read while empty is rejected even if a write is accepted in the same cycle. No bypass when empty.

- Count update:
  - write only: +1;
  - read only: -1;
  - both accepted: unchanged;
  - neither: unchanged.

- Flags:
  - All flags and level are registered, derived from the next-count value.
  - They are valid in the cycle after the causing edge (1-cycle write-to-not-empty latency).
  - wr_full = (level == DEPTH); rd_empty = (level == 0).

- Error pulses:
  - wr_overflow = 1 for exactly one cycle after each rejected write.
  - rd_underflow = 1 for exactly one cycle after each rejected read.
  - A rejected request never changes pointers, count or memory.

- FWFT = 0:
  - On an accepted read, rd_data <= mem[rptr], visible the cycle after rd_en.
  - rd_data holds its last value otherwise, including after a rejected read.

- FWFT = 1:
  - rd_data is continuously the head entry, mem[rptr], whenever rd_empty = 0.
  - rd_en acts as pop/acknowledge; the next entry appears the cycle after the pop.
  - rd_data while empty is don't-care; hold the last head value.

- Wrap-around: pointers wrap from DEPTH-1 to 0 with no gap. Ordering is strictly preserved across wrap.

- Thresholds: each threshold asserts and deasserts on the same registered update as level. No hysteresis.

Test Plan:
- Reset then idle (DEPTH=16):
  - after reset: rd_empty=1, rd_almost_empty=1, level=0, wr_full=0;
  - assert rst mid-fill at level=5 → level=0 and rd_empty=1 immediately, asynchronously.
- Fill 16 writes of 0x0..0xF, then write 0xAA → level 1..16, wr_almost_full rises when level=14, wr_full=1 at level 16; the 0xAA write produces wr_overflow pulse=1 for one cycle and level stays 16.
- Drain all (FWFT=0):
  - data out is 0x0..0xF in order, each one cycle after rd_en;
  - a 17th read produces rd_underflow=1 for one cycle and rd_data holds 0xF.
- Simultaneous read+write:
  - at level=8 for 20 cycles → level stays 8, pointers wrap, output order is preserved;
  - at level=0, write+read in the same cycle → write accepted, rd_underflow=1, level=1;
  - at level=16, write+read in the same cycle → read accepted, wr_overflow=1, level=15.
- FWFT=1: write 0x11, 0x22 → rd_data=0x11 the cycle after rd_empty falls with no rd_en; pop → rd_data=0x22 next cycle; pop → rd_empty=1.
- Random write/read at ~50% each for 10k cycles vs. a scoreboard model → exact data order, level, all flags match every cycle, and every over/underflow pulse is accounted for.
